uart_tx_fifo_drain: RTL and testbench
=====================================

Name: uart_tx_fifo_drain

Overview:
- Downstream consumer of the asynchronous FIFO's read side. Runs in the read clock domain.
- Pops one word whenever the FIFO is non-empty and serializes it as a UART frame on TX_OUT: start bit, data LSB-first, optional parity, one stop bit.
- One bit per CLK cycle; CLK is the TX bit clock.
- Back-to-back frames are sent with no idle gap while data remains.

Parameters:
- DATA_WIDTH, 8, width of FIFO word and of the UART data field.

Ports:
- CLK  in  1  TX bit clock, same as the FIFO read clock.
- RST  in  1  asynchronous active-low reset.
- EMPTY  in  1  FIFO empty flag, read-domain.
- RD_DATA  in  DATA_WIDTH  FIFO head word; valid whenever EMPTY=0.
- PAR_EN  in  1  1 = append parity bit.
- PAR_TYP  in  1  0 = even parity, 1 = odd parity.
- R_INC  out  1  FIFO pop strobe, one cycle per word.
- TX_OUT  out  1  serial line, idle high.
- BUSY  out  1  high while a frame is on the line.

Behaviour:
- One clock (CLK). Reset RST is asynchronous, active-low.
- While RST=0:
  - state = IDLE, TX_OUT = 1, BUSY = 0, R_INC = 0.
  - Shift register, bit counter, parity and config latches cleared.
- FSM states (each names the bit currently driven on TX_OUT): IDLE, START, DATA, PARITY, STOP.
- Fetch condition: (state==IDLE or state==STOP) and EMPTY==0.
- R_INC is combinational and equals the fetch condition. It is high for exactly one cycle per word.
- On the rising edge ending a fetch cycle:
  - data_reg <= RD_DATA.
  - par_en_q <= PAR_EN.
  - par_bit <= ^RD_DATA ^ PAR_TYP.
  - TX_OUT <= 0; state <= START.
- START: one cycle. Next state DATA, with TX_OUT <= data_reg[0] and bit_cnt <= 0.
- DATA: one cycle per bit, LSB first.
  - At bit_cnt == DATA_WIDTH-1: next state is PARITY (TX_OUT <= par_bit) if par_en_q, else STOP (TX_OUT <= 1).
- PARITY: one cycle. Next state STOP, TX_OUT <= 1.
- STOP: one cycle.
  - If the fetch condition holds, a new fetch occurs (back-to-back, zero gap).
  - Otherwise next state IDLE, TX_OUT stays 1.
- Latency: start bit appears on the edge after the cycle in which R_INC=1.
- Frame length is 2 + DATA_WIDTH + par_en_q cycles.
- BUSY is registered. It is 1 in START, DATA, PARITY and STOP, and 0 in IDLE.
- PAR_EN and PAR_TYP are sampled only at fetch. Changes mid-frame do not affect the current frame.
- EMPTY rising mid-frame has no effect; it is only sampled in IDLE or STOP.
- TX_OUT, BUSY and state are registered. No glitches on TX_OUT.
- Reset mid-frame: TX_OUT returns to 1 immediately (asynchronous). The popped word is lost and is not re-read.
- bit_cnt width is $clog2(DATA_WIDTH). Wrap is never reached because DATA exits at DATA_WIDTH-1.

Decomposition:
- Shared package (uart_tx_pkg):
  - State enum (IDLE, START, DATA, PARITY, STOP).
  - PAR_EVEN=0 and PAR_ODD=1 constants.
  - Line constants IDLE_LVL=1 and START_LVL=0.
- One sub-module, uart_tx_serializer:
  - Holds data_reg, bit_cnt, load and shift control, and the current-bit output.
  - The FSM, parity latch and R_INC logic stay in the top.

Test Plan:
1. Idle hold: EMPTY=1 for 20 cycles after reset release -> TX_OUT=1, R_INC=0 and BUSY=0 throughout.
2. Single word, even parity: RD_DATA=0xA5, PAR_EN=1, PAR_TYP=0, EMPTY=0 for one word.
   - Exactly one R_INC pulse.
   - TX_OUT = 0,1,0,1,0,0,1,0,1,0,1 (11 cycles), then idle.
   - BUSY high for exactly 11 cycles.
3. Odd parity, zero data: RD_DATA=0x00, PAR_EN=1, PAR_TYP=1 -> TX_OUT = 0, eight 0s, 1, 1.
4. Back-to-back, no parity: FIFO holds 0x01 then 0x80, PAR_EN=0.
   - R_INC pulses exactly 10 cycles apart.
   - TX_OUT = 0,1,0,0,0,0,0,0,0,1 then 0,0,0,0,0,0,0,0,1,1.
   - No idle cycle between frames; BUSY stays high for 20 cycles.
5. Config change mid-frame: start 0xFF with PAR_EN=1, PAR_TYP=0, then toggle PAR_EN=0 during DATA -> parity bit 0 still sent, 11-cycle frame.
6. Reset mid-frame: assert RST=0 during DATA bit 3 of 0x3C, then release with EMPTY=1.
   - TX_OUT=1 and BUSY=0 within the reset assertion, no clock needed.
   - No R_INC after release.

Source files
------------

// File: rtl/uart_tx_pkg.sv
// Shared definitions for the FIFO-draining UART transmitter.
// Holds the FSM state encoding, the parity selector values and the line levels.
package uart_tx_pkg;

  // Each state names the bit currently on the line.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam logic PAR_EVEN  = 1'b0;
  localparam logic PAR_ODD   = 1'b1;

  localparam logic IDLE_LVL  = 1'b1;
  localparam logic START_LVL = 1'b0;

endpackage

// File: rtl/uart_tx_serializer.sv
// Data path of the transmitter: loads a FIFO word at fetch and shifts it out LSB first.
// cur_bit is the bit to put on the line next; last_bit flags the final data bit.
module uart_tx_serializer
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  load,
  input  state_t                state,
  input  logic [DATA_WIDTH-1:0] load_data,
  output logic                  cur_bit,
  output logic                  last_bit
);

  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  logic [DATA_WIDTH-1:0] data_reg;
  logic [CW-1:0]         bit_cnt_reg;
  logic                  shift;

  assign last_bit = (bit_cnt_reg == CW'(DATA_WIDTH - 1));
  assign cur_bit  = data_reg[0];

  // START puts bit 0 on the line, so the register already advances there;
  // inside DATA bit k is driving while bit k+1 sits at position 0.
  assign shift = (state == START) || ((state == DATA) && !last_bit);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      data_reg <= '0;
    end else if (load) begin
      data_reg <= load_data;
    end else if (shift) begin
      data_reg <= data_reg >> 1;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      bit_cnt_reg <= '0;
    end else if (state == START) begin
      bit_cnt_reg <= '0;
    end else if ((state == DATA) && !last_bit) begin
      bit_cnt_reg <= bit_cnt_reg + CW'(1);
    end
  end

endmodule

// File: rtl/uart_tx_fifo_drain.sv
// Pops words from the read side of a FIFO and sends each as a UART frame, one bit per CLK.
// Frames run back to back while the FIFO stays non-empty; parity config is latched per word.
module uart_tx_fifo_drain
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  EMPTY,
  input  logic [DATA_WIDTH-1:0] RD_DATA,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  R_INC,
  output logic                  TX_OUT,
  output logic                  BUSY
);

  state_t state_reg, state_next;
  logic   tx_next;
  logic   fetch;
  logic   par_en_q, par_bit;
  logic   ser_bit, ser_last;

  assign fetch = ((state_reg == IDLE) || (state_reg == STOP)) && !EMPTY;
  // Gated so no pop is requested while reset holds the FSM.
  assign R_INC = fetch & RST;

  uart_tx_serializer #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_serializer (
    .CLK      (CLK),
    .RST      (RST),
    .load     (fetch),
    .state    (state_reg),
    .load_data(RD_DATA),
    .cur_bit  (ser_bit),
    .last_bit (ser_last)
  );

  always_comb begin
    state_next = state_reg;
    tx_next    = TX_OUT;
    case (state_reg)
      IDLE, STOP: begin
        if (fetch) begin
          state_next = START;
          tx_next    = START_LVL;
        end else begin
          state_next = IDLE;
          tx_next    = IDLE_LVL;
        end
      end
      START: begin
        state_next = DATA;
        tx_next    = ser_bit;
      end
      DATA: begin
        if (!ser_last) begin
          tx_next = ser_bit;
        end else if (par_en_q) begin
          state_next = PARITY;
          tx_next    = par_bit;
        end else begin
          state_next = STOP;
          tx_next    = IDLE_LVL;
        end
      end
      PARITY: begin
        state_next = STOP;
        tx_next    = IDLE_LVL;
      end
      default: begin
        state_next = IDLE;
        tx_next    = IDLE_LVL;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_reg <= IDLE;
      TX_OUT    <= IDLE_LVL;
      BUSY      <= 1'b0;
    end else begin
      state_reg <= state_next;
      TX_OUT    <= tx_next;
      BUSY      <= (state_next != IDLE);
    end
  end

  // Parity settings are captured with the word so mid-frame changes wait for the next fetch.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      par_en_q <= 1'b0;
      par_bit  <= PAR_EVEN;
    end else if (fetch) begin
      par_en_q <= PAR_EN;
      par_bit  <= (^RD_DATA) ^ PAR_TYP;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// Bench for uart_tx_fifo_drain: a FIFO model feeds the DUT and a scoreboard queue
// holds the expected line bits of every popped word, compared while BUSY is high.
module tb_uart_tx_fifo_drain;

  typedef struct {
    logic [7:0] data;
    string      frame;
  } word_t;

  typedef struct {
    logic [7:0] data;
    bit         par_en;
    bit         par_typ;
    string      frame;
  } vec_t;

  logic       CLK;
  logic       RST;
  logic       EMPTY;
  logic [7:0] RD_DATA;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic       R_INC;
  logic       TX_OUT;
  logic       BUSY;

  int checks   = 0;
  int failures = 0;

  word_t fifo_q[$];
  bit    exp_q[$];
  bit    pop_pending = 0;
  int    cyc = 0;
  int    r_inc_cnt = 0;
  int    busy_cnt = 0;
  int    busy_run = 0;
  int    busy_max = 0;
  int    last_rinc = -1;
  int    last_gap = 0;

  uart_tx_fifo_drain #(.DATA_WIDTH(8)) dut (
    .CLK    (CLK),
    .RST    (RST),
    .EMPTY  (EMPTY),
    .RD_DATA(RD_DATA),
    .PAR_EN (PAR_EN),
    .PAR_TYP(PAR_TYP),
    .R_INC  (R_INC),
    .TX_OUT (TX_OUT),
    .BUSY   (BUSY)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk_bit(string name, logic act, logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %b expected %b", name, cyc, act, exp);
    end
  endtask

  task automatic chk_int(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  function automatic string model_frame(logic [7:0] d, bit pe, bit pt);
    string s;
    s = "0";
    for (int i = 0; i < 8; i++) s = {s, d[i] ? "1" : "0"};
    if (pe) s = {s, ((^d) ^ pt) ? "1" : "0"};
    s = {s, "1"};
    return s;
  endfunction

  task automatic push_word(logic [7:0] d, string fr);
    word_t w;
    w.data  = d;
    w.frame = fr;
    fifo_q.push_back(w);
  endtask

  task automatic drive_fifo();
    EMPTY   = (fifo_q.size() == 0);
    RD_DATA = EMPTY ? 8'h00 : fifo_q[0].data;
  endtask

  // One clock: retire the popped word, present the FIFO head, then check outputs.
  task automatic tick();
    word_t w;
    string fr;
    bit    e;
    @(posedge CLK);
    #1;
    cyc++;
    if (pop_pending) begin
      w = fifo_q.pop_front();
      pop_pending = 0;
    end
    drive_fifo();
    #1;
    if (BUSY) begin
      busy_cnt++;
      busy_run++;
      if (busy_run > busy_max) busy_max = busy_run;
      if (exp_q.size() == 0) begin
        chk_int("tx_unexpected_busy", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk_bit("tx_bit", TX_OUT, e);
      end
    end else begin
      busy_run = 0;
      chk_bit("tx_idle", TX_OUT, 1'b1);
    end
    if (R_INC) begin
      r_inc_cnt++;
      if (last_rinc >= 0) last_gap = cyc - last_rinc;
      last_rinc = cyc;
      if (fifo_q.size() == 0) begin
        chk_int("r_inc_when_empty", 1, 0);
      end else begin
        fr = fifo_q[0].frame;
        for (int i = 0; i < fr.len(); i++) exp_q.push_back(fr[i] == 8'h31);
        pop_pending = 1;
      end
    end
  endtask

  vec_t vecs[7];
  int   r0, b0;

  initial begin
    vecs[0] = '{8'hA5, 1'b1, 1'b0, "01010010101"};
    vecs[1] = '{8'h00, 1'b1, 1'b1, "00000000011"};
    vecs[2] = '{8'h01, 1'b0, 1'b0, "0100000001"};
    vecs[3] = '{8'h80, 1'b0, 1'b1, "0000000011"};
    vecs[4] = '{8'hFF, 1'b1, 1'b0, "01111111101"};
    vecs[5] = '{8'h3C, 1'b0, 1'b1, "0001111001"};
    vecs[6] = '{8'h7E, 1'b1, 1'b1, "00111111011"};

    RST = 1'b0; EMPTY = 1'b1; RD_DATA = 8'h00; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    #12;
    chk_bit("reset_tx", TX_OUT, 1'b1);
    chk_bit("reset_busy", BUSY, 1'b0);
    chk_bit("reset_rinc", R_INC, 1'b0);
    EMPTY = 1'b0; RD_DATA = 8'h55;
    #1;
    chk_bit("reset_rinc_nonempty", R_INC, 1'b0);
    EMPTY = 1'b1; RD_DATA = 8'h00;
    #7;
    RST = 1'b1;

    // Idle hold with an empty FIFO.
    repeat (20) tick();
    chk_int("idle_rinc_count", r_inc_cnt, 0);
    chk_int("idle_busy_count", busy_cnt, 0);

    // Single words, one per vector.
    for (int v = 0; v < 7; v++) begin
      PAR_EN = vecs[v].par_en;
      PAR_TYP = vecs[v].par_typ;
      r0 = r_inc_cnt; b0 = busy_cnt;
      push_word(vecs[v].data, vecs[v].frame);
      repeat (16) tick();
      chk_int($sformatf("vec%0d_rinc_count", v), r_inc_cnt - r0, 1);
      chk_int($sformatf("vec%0d_busy_len", v), busy_cnt - b0, vecs[v].frame.len());
      chk_int($sformatf("vec%0d_exp_left", v), exp_q.size(), 0);
    end

    // Back-to-back frames without parity.
    PAR_EN = 1'b0; PAR_TYP = 1'b0;
    r0 = r_inc_cnt; b0 = busy_cnt; busy_max = 0; last_rinc = -1; last_gap = 0;
    push_word(8'h01, "0100000001");
    push_word(8'h80, "0000000011");
    repeat (26) tick();
    chk_int("b2b_rinc_count", r_inc_cnt - r0, 2);
    chk_int("b2b_rinc_gap", last_gap, 10);
    chk_int("b2b_busy_run", busy_max, 20);
    chk_int("b2b_busy_len", busy_cnt - b0, 20);
    chk_int("b2b_exp_left", exp_q.size(), 0);

    // Parity config toggled during DATA must not affect the frame in flight.
    PAR_EN = 1'b1; PAR_TYP = 1'b0;
    r0 = r_inc_cnt; b0 = busy_cnt;
    push_word(8'hFF, "01111111101");
    repeat (5) tick();
    PAR_EN = 1'b0; PAR_TYP = 1'b1;
    repeat (12) tick();
    chk_int("cfg_busy_len", busy_cnt - b0, 11);
    chk_int("cfg_rinc_count", r_inc_cnt - r0, 1);
    chk_int("cfg_exp_left", exp_q.size(), 0);

    // Reset during DATA bit 3: line returns high without a clock edge, word is dropped.
    PAR_EN = 1'b0; PAR_TYP = 1'b0;
    push_word(8'h3C, "0001111001");
    repeat (6) tick();
    chk_bit("pre_reset_busy", BUSY, 1'b1);
    #2;
    RST = 1'b0;
    #1;
    chk_bit("midreset_tx", TX_OUT, 1'b1);
    chk_bit("midreset_busy", BUSY, 1'b0);
    chk_bit("midreset_rinc", R_INC, 1'b0);
    exp_q.delete();
    pop_pending = 0;
    #1;
    RST = 1'b1;
    r0 = r_inc_cnt; b0 = busy_cnt;
    repeat (12) tick();
    chk_int("post_reset_rinc", r_inc_cnt - r0, 0);
    chk_int("post_reset_busy", busy_cnt - b0, 0);

    // Random burst, odd parity, frames back to back.
    PAR_EN = 1'b1; PAR_TYP = 1'b1;
    r0 = r_inc_cnt; b0 = busy_cnt; busy_max = 0;
    for (int k = 0; k < 6; k++) begin
      logic [7:0] d;
      d = 8'($urandom_range(0, 255));
      push_word(d, model_frame(d, 1'b1, 1'b1));
    end
    repeat (72) tick();
    chk_int("burst_rinc_count", r_inc_cnt - r0, 6);
    chk_int("burst_busy_run", busy_max, 66);
    chk_int("burst_exp_left", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
